// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - fetch/load-store/memory port bundle for mem_port_arbiter
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  localparam int MASK_W = DATA_W / 8;

  logic              i_if_req;
  logic [ADDR_W-1:0] i_if_addr;
  logic              o_if_gnt;
  logic              o_if_rvalid;
  logic [DATA_W-1:0] o_if_rdata;

  logic              i_d_req;
  logic              i_d_wen;
  logic [ADDR_W-1:0] i_d_addr;
  logic [DATA_W-1:0] i_d_wdata;
  logic [MASK_W-1:0] i_d_mask;
  logic              o_d_gnt;
  logic              o_d_rvalid;
  logic [DATA_W-1:0] o_d_rdata;

  logic              o_mem_req;
  logic              o_mem_wen;
  logic [ADDR_W-1:0] o_mem_addr;
  logic [DATA_W-1:0] o_mem_wdata;
  logic [MASK_W-1:0] o_mem_mask;
  logic              i_mem_ready;
  logic              i_mem_rvalid;
  logic [DATA_W-1:0] i_mem_rdata;

  logic              o_timeout;

  // Arbiter side: consumes requests and memory responses, drives grants and memory requests.
  modport master (
    input  i_if_req, i_if_addr,
    input  i_d_req, i_d_wen, i_d_addr, i_d_wdata, i_d_mask,
    input  i_mem_ready, i_mem_rvalid, i_mem_rdata,
    output o_if_gnt, o_if_rvalid, o_if_rdata,
    output o_d_gnt, o_d_rvalid, o_d_rdata,
    output o_mem_req, o_mem_wen, o_mem_addr, o_mem_wdata, o_mem_mask,
    output o_timeout
  );

  // Environment side: the two pipeline requesters plus the memory.
  modport slave (
    output i_if_req, i_if_addr,
    output i_d_req, i_d_wen, i_d_addr, i_d_wdata, i_d_mask,
    output i_mem_ready, i_mem_rvalid, i_mem_rdata,
    input  o_if_gnt, o_if_rvalid, o_if_rdata,
    input  o_d_gnt, o_d_rvalid, o_d_rdata,
    input  o_mem_req, o_mem_wen, o_mem_addr, o_mem_wdata, o_mem_mask,
    input  o_timeout
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - fetch vs load/store arbiter for the unified memory port (optional abort: MEM_ARB_TIMEOUT_EN)
module mem_port_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 64
) (
  input logic             i_clk,
  input logic             i_rst,
  mem_port_arbiter_if.master bus
);
  localparam int MASK_W = DATA_W / 8;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  state_t state, state_nxt;
  logic   owner_d;   // 1: load/store owns the transaction, 0: fetch
  logic   if_prio;   // fetch gets the next contested slot
  logic   any_req;
  logic   pick_d;
  logic   done;
  logic   abort;
  logic   expired;

  // A timeout below 2 leaves memory no cycle to accept; this block only exists if that is configured.
  if (TIMEOUT < 2) begin : g_timeout_too_small
  end

  assign any_req   = bus.i_if_req | bus.i_d_req;
  assign bus.o_mem_req = (state == ISSUE);
  assign bus.o_if_gnt  = bus.o_mem_req & bus.i_mem_ready & ~owner_d;
  assign bus.o_d_gnt   = bus.o_mem_req & bus.i_mem_ready & owner_d;

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int                CNT_W    = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0]  TMO_LAST = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] tmo_cnt;
  logic             timeout_q;

  // Occupancy counter: zero while idle, counts ISSUE/WAIT cycles, saturates at the last allowed cycle.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      tmo_cnt <= '0;
    end else if (state == IDLE) begin
      tmo_cnt <= '0;
    end else if (tmo_cnt != TMO_LAST) begin
      tmo_cnt <= tmo_cnt + 1'b1;
    end
  end

  assign expired = (tmo_cnt == TMO_LAST);

  // Abort pulse accompanies the owner's zero-data response.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= abort;
    end
  end

  assign bus.o_timeout = timeout_q;
`else
  assign expired       = 1'b0;
  assign bus.o_timeout = 1'b0;
`endif

  // Next state; a memory handshake in the final counted cycle wins over the abort.
  always_comb begin
    state_nxt = state;
    pick_d    = bus.i_d_req & (~bus.i_if_req | ~if_prio);
    done      = 1'b0;
    abort     = 1'b0;
    case (state)
      IDLE: begin
        if (any_req) state_nxt = ISSUE;
      end
      ISSUE: begin
        if (bus.i_mem_ready) begin
          state_nxt = WAIT;
        end else if (expired) begin
          abort     = 1'b1;
          state_nxt = IDLE;
        end
      end
      WAIT: begin
        if (bus.i_mem_rvalid) begin
          done      = 1'b1;
          state_nxt = IDLE;
        end else if (expired) begin
          abort     = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Capture owner and payload at arbitration; update the fetch anti-starvation flag.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      owner_d         <= 1'b0;
      if_prio         <= 1'b0;
      bus.o_mem_wen   <= 1'b0;
      bus.o_mem_addr  <= '0;
      bus.o_mem_wdata <= '0;
      bus.o_mem_mask  <= '0;
    end else if (state == IDLE && any_req) begin
      owner_d <= pick_d;
      if (pick_d) begin
        if (bus.i_if_req) if_prio <= 1'b1;
        bus.o_mem_wen   <= bus.i_d_wen;
        bus.o_mem_addr  <= bus.i_d_addr;
        bus.o_mem_wdata <= bus.i_d_wdata;
        bus.o_mem_mask  <= bus.i_d_mask;
      end else begin
        if_prio         <= 1'b0;
        bus.o_mem_wen   <= 1'b0;
        bus.o_mem_addr  <= bus.i_if_addr;
        bus.o_mem_wdata <= '0;
        bus.o_mem_mask  <= {MASK_W{1'b1}};
      end
    end
  end

  // Route the completion (or abort with zero data) back to the owner, one cycle after memory.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      bus.o_if_rvalid <= 1'b0;
      bus.o_d_rvalid  <= 1'b0;
      bus.o_if_rdata  <= '0;
      bus.o_d_rdata   <= '0;
    end else begin
      bus.o_if_rvalid <= (done | abort) & ~owner_d;
      bus.o_d_rvalid  <= (done | abort) & owner_d;
      if (done & ~owner_d) bus.o_if_rdata <= bus.i_mem_rdata;
      else if (abort & ~owner_d) bus.o_if_rdata <= '0;
      if (done & owner_d) bus.o_d_rdata <= bus.i_mem_rdata;
      else if (abort & owner_d) bus.o_d_rdata <= '0;
    end
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - scoreboard bench for mem_port_arbiter
module tb_mem_port_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;

  typedef struct {
    bit          is_d;
    logic        wen;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  mask;
  } gnt_t;

  typedef struct {
    bit          is_d;
    logic [31:0] data;
    logic        tmo;
    bit          chk_data;
  } rsp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  gnt_t gq[$];
  rsp_t rq[$];
  gnt_t mg;
  rsp_t mr;

  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(8)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus.master)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_mem_req"}, 64'(bus.o_mem_req), 0);
    check({tag, "_mem_payload"}, 64'({bus.o_mem_wen, bus.o_mem_addr, bus.o_mem_mask}), 0);
    check({tag, "_mem_wdata"}, 64'(bus.o_mem_wdata), 0);
    check({tag, "_gnt"}, 64'({bus.o_if_gnt, bus.o_d_gnt}), 0);
    check({tag, "_rvalid"}, 64'({bus.o_if_rvalid, bus.o_d_rvalid}), 0);
    check({tag, "_if_rdata"}, 64'(bus.o_if_rdata), 0);
    check({tag, "_d_rdata"}, 64'(bus.o_d_rdata), 0);
    check({tag, "_timeout"}, 64'(bus.o_timeout), 0);
  endtask

  // Memory side of one transaction: wait for the request, stall, accept, then answer.
  task automatic serve(input gnt_t g, input int rdy_wait, input int rv_wait,
                       input logic [31:0] data, input bit drop);
    rsp_t r;
    int   n = 0;
    r.is_d = g.is_d;
    r.data = data;
    r.tmo = 1'b0;
    r.chk_data = !g.wen;
    gq.push_back(g);
    rq.push_back(r);
    while (!bus.o_mem_req && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check("mem_req_seen", 64'(bus.o_mem_req), 1);
    for (int i = 0; i < rdy_wait; i++) begin
      check("stall_mem_req", 64'(bus.o_mem_req), 1);
      check("stall_payload", {bus.o_mem_wen, bus.o_mem_mask, bus.o_mem_addr, bus.o_mem_wdata[26:0]},
            {g.wen, g.mask, g.addr, g.wdata[26:0]});
      check("stall_no_gnt", 64'({bus.o_if_gnt, bus.o_d_gnt}), 0);
      @(posedge clk); #1;
    end
    bus.i_mem_ready = 1'b1;
    @(posedge clk); #1;
    bus.i_mem_ready = 1'b0;
    if (drop) begin
      if (g.is_d) bus.i_d_req = 1'b0;
      else bus.i_if_req = 1'b0;
    end
    repeat (rv_wait - 1) begin
      @(posedge clk); #1;
    end
    bus.i_mem_rvalid = 1'b1;
    bus.i_mem_rdata  = data;
    @(posedge clk); #1;
    bus.i_mem_rvalid = 1'b0;
    bus.i_mem_rdata  = 32'h0;
  endtask

  // Monitor: pops the scoreboard whenever the DUT grants or responds.
  always @(negedge clk) begin
    if (!rst) begin
      check("rvalid_exclusive", 64'(bus.o_if_rvalid & bus.o_d_rvalid), 0);
      if (bus.o_if_gnt || bus.o_d_gnt) begin
        if (gq.size() == 0) begin
          check("unexpected_gnt", 64'({bus.o_if_gnt, bus.o_d_gnt}), 0);
        end else begin
          mg = gq.pop_front();
          check("gnt_owner", 64'({bus.o_d_gnt, bus.o_if_gnt}), 64'({mg.is_d, !mg.is_d}));
          check("gnt_wen", 64'(bus.o_mem_wen), 64'(mg.wen));
          check("gnt_addr", 64'(bus.o_mem_addr), 64'(mg.addr));
          check("gnt_wdata", 64'(bus.o_mem_wdata), 64'(mg.wdata));
          check("gnt_mask", 64'(bus.o_mem_mask), 64'(mg.mask));
        end
      end
      if (bus.o_if_rvalid || bus.o_d_rvalid) begin
        if (rq.size() == 0) begin
          check("unexpected_rvalid", 64'({bus.o_if_rvalid, bus.o_d_rvalid}), 0);
        end else begin
          mr = rq.pop_front();
          check("rsp_owner", 64'({bus.o_d_rvalid, bus.o_if_rvalid}), 64'({mr.is_d, !mr.is_d}));
          check("rsp_timeout", 64'(bus.o_timeout), 64'(mr.tmo));
          if (mr.chk_data) begin
            check("rsp_data", 64'(mr.is_d ? bus.o_d_rdata : bus.o_if_rdata), 64'(mr.data));
          end
        end
      end else begin
        check("timeout_without_rsp", 64'(bus.o_timeout), 0);
      end
    end
  end

  initial begin
    gnt_t gf, gs, gd, gi;
    int   n;
    bus.i_if_req = 1'b0; bus.i_if_addr = '0;
    bus.i_d_req = 1'b0; bus.i_d_wen = 1'b0; bus.i_d_addr = '0;
    bus.i_d_wdata = '0; bus.i_d_mask = '0;
    bus.i_mem_ready = 1'b0; bus.i_mem_rvalid = 1'b0; bus.i_mem_rdata = '0;

    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst = 1'b0;
    @(posedge clk); #1;

    // Single fetch: gnt at N+1, response 0x00500093 at N+3.
    bus.i_if_req = 1'b1; bus.i_if_addr = 32'h100;
    gf = '{is_d: 1'b0, wen: 1'b0, addr: 32'h100, wdata: 32'h0, mask: 4'hF};
    serve(gf, 0, 1, 32'h00500093, 1'b1);
    check("fetch_rvalid_n3", 64'(bus.o_if_rvalid), 1);
    check("fetch_rdata_n3", 64'(bus.o_if_rdata), 64'h00500093);
    repeat (2) @(posedge clk);
    #1;

    // Store with memory stalling 5 cycles; ack one cycle before o_d_rvalid.
    bus.i_d_req = 1'b1; bus.i_d_wen = 1'b1; bus.i_d_addr = 32'h200;
    bus.i_d_wdata = 32'hDEADBEEF; bus.i_d_mask = 4'b0011;
    gs = '{is_d: 1'b1, wen: 1'b1, addr: 32'h200, wdata: 32'hDEADBEEF, mask: 4'b0011};
    serve(gs, 5, 2, 32'h0, 1'b1);
    check("store_ack_rvalid", 64'({bus.o_d_rvalid, bus.o_if_rvalid}), 64'b10);
    repeat (2) @(posedge clk);
    #1;

    // Both requesting continuously: D, IF, D, IF.
    bus.i_if_req = 1'b1; bus.i_if_addr = 32'h300;
    bus.i_d_req = 1'b1; bus.i_d_wen = 1'b0; bus.i_d_addr = 32'h400;
    bus.i_d_wdata = 32'h12345678; bus.i_d_mask = 4'hF;
    gd = '{is_d: 1'b1, wen: 1'b0, addr: 32'h400, wdata: 32'h12345678, mask: 4'hF};
    gi = '{is_d: 1'b0, wen: 1'b0, addr: 32'h300, wdata: 32'h0, mask: 4'hF};
    for (int k = 0; k < 4; k++) begin
      serve((k % 2 == 0) ? gd : gi, 0, 1, 32'hA0 + 32'(k), 1'b0);
    end
    bus.i_if_req = 1'b0; bus.i_d_req = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Reset while waiting for the response; the late rvalid must be ignored.
    bus.i_if_req = 1'b1; bus.i_if_addr = 32'h700;
    gi.addr = 32'h700;
    gq.push_back(gi);
    n = 0;
    while (!bus.o_mem_req && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check("midrst_mem_req_seen", 64'(bus.o_mem_req), 1);
    bus.i_mem_ready = 1'b1;
    @(posedge clk); #1;
    bus.i_mem_ready = 1'b0; bus.i_if_req = 1'b0;
    #2 rst = 1'b1;
    #1 check_all_zero("midrst");
    @(posedge clk); #1;
    rst = 1'b0;
    bus.i_mem_rvalid = 1'b1; bus.i_mem_rdata = 32'hBAD0BAD0;
    @(posedge clk); #1;
    bus.i_mem_rvalid = 1'b0; bus.i_mem_rdata = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    check("late_rvalid_ignored", 64'({bus.o_if_rvalid, bus.o_d_rvalid}), 0);
    check("late_rvalid_idle", 64'(bus.o_mem_req), 0);

`ifdef MEM_ARB_TIMEOUT_EN
    // Load never answered: abort after 8 cycles, then the waiting fetch goes through.
    begin
      rsp_t rt;
      bit   seen = 1'b0;
      bus.i_d_req = 1'b1; bus.i_d_wen = 1'b0; bus.i_d_addr = 32'h500;
      bus.i_d_wdata = 32'h0; bus.i_d_mask = 4'hF;
      bus.i_if_req = 1'b1; bus.i_if_addr = 32'h600;
      rt = '{is_d: 1'b1, data: 32'h0, tmo: 1'b1, chk_data: 1'b1};
      rq.push_back(rt);
      for (int i = 0; i < 30 && !seen; i++) begin
        @(negedge clk);
        if (bus.o_timeout) seen = 1'b1;
      end
      check("timeout_seen", 64'(seen), 1);
      @(posedge clk); #1;
      bus.i_d_req = 1'b0;
      gi.addr = 32'h600;
      serve(gi, 0, 1, 32'hCAFE0001, 1'b1);
      check("post_timeout_fetch", 64'({bus.o_if_rvalid, bus.o_if_rdata}), {1'b1, 32'hCAFE0001});
    end
`endif

    repeat (3) @(posedge clk);
    #1;
    check("gnt_queue_drained", 64'(gq.size()), 0);
    check("rsp_queue_drained", 64'(rq.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Arbitrates the single unified memory port between the instruction-fetch stage and the load/store (MEM) stage of the RISC-V core. Load/store requests come from the `o_memRead`/`o_memWrite` control path. The block serialises one transaction at a time through a small FSM and handles the request/accept/response handshake with memory. It routes each response back to its originator and applies data-priority arbitration with anti-starvation for fetch.

## Interface
Parameters:
- `ADDR_W`, 32, address width
- `DATA_W`, 32, data width; mask width is `DATA_W/8`
- `TIMEOUT`, 64, cycles in ISSUE+WAIT before abort (used only with the macro)

Ports:
- `i_clk`  in  1  clock; all state changes on the rising edge
- `i_rst`  in  1  reset; asynchronous, active-high
- `i_if_req`  in  1  fetch request (level)
- `i_if_addr`  in  ADDR_W  fetch address
- `o_if_gnt`  out  1  fetch request accepted by memory (1-cycle pulse)
- `o_if_rvalid`  out  1  fetch response valid (1-cycle pulse)
- `o_if_rdata`  out  DATA_W  fetch response data
- `i_d_req`  in  1  load/store request (level)
- `i_d_wen`  in  1  1 = store, 0 = load
- `i_d_addr`  in  ADDR_W  data address
- `i_d_wdata`  in  DATA_W  store data
- `i_d_mask`  in  DATA_W/8  byte enables
- `o_d_gnt`  out  1  data request accepted (1-cycle pulse)
- `o_d_rvalid`  out  1  data response or store ack (1-cycle pulse)
- `o_d_rdata`  out  DATA_W  load data
- `o_mem_req`  out  1  request to memory
- `o_mem_wen`, `o_mem_addr`, `o_mem_wdata`, `o_mem_mask`  out  1/ADDR_W/DATA_W/DATA_W/8  registered request payload
- `i_mem_ready`  in  1  memory accepts the request this cycle
- `i_mem_rvalid`  in  1  memory response or write ack
- `i_mem_rdata`  in  DATA_W  memory read data
- `o_timeout`  out  1  transaction aborted (1-cycle pulse)

## Operation
- FSM states: IDLE, ISSUE, WAIT.
- IDLE:
  - If any request is high, select the owner, register the payload and owner into `o_mem_*`/`owner`, and go to ISSUE.
  - Stores take payload from `i_d_*`. Fetches drive `o_mem_wen`=0, `o_mem_mask`=all-ones and `o_mem_wdata`=0.
- Arbitration when both requests are high:
  - Data wins unless the `if_prio` flag is set.
  - `if_prio` is set when data wins while `i_if_req` is high. It clears when fetch wins.
  - A single requester always wins.
- ISSUE:
  - `o_mem_req`=1.
  - When `i_mem_ready`=1: pulse the owner's `o_*_gnt` (combinational: `o_mem_req & i_mem_ready & owner`) and go to WAIT.
  - `i_mem_rvalid` is ignored in ISSUE.
- WAIT:
  - `o_mem_req`=0.
  - On `i_mem_rvalid`: register `i_mem_rdata` into the owner's rdata, pulse the owner's `o_*_rvalid` next cycle, and go to IDLE.
  - Stores also complete on `i_mem_rvalid` (ack); `o_d_rdata` is don't-care for stores.
- `i_mem_rvalid` in IDLE or ISSUE is ignored.
- Requesters must hold `req` and payload stable until `gnt`. Dropping `req` before `gnt` is a protocol violation; the arbiter does not cancel a transaction already in ISSUE.
- Reset, including mid-transaction:
  - State goes to IDLE and `if_prio` to 0.
  - All outputs go to 0: `o_mem_*`, `gnt`, `rvalid`, `rdata`, `o_timeout`.
  - The in-flight transaction is dropped, and its late `i_mem_rvalid` is ignored.

## Timing
- Requests are sampled in IDLE at cycle N.
- `o_mem_req` is high from N+1.
- With ready at N+1: `gnt` at N+1 and WAIT at N+2.
- With rvalid at N+2: `o_*_rvalid`/rdata at N+3, IDLE at N+3, next arbitration at N+3.
- Minimum occupancy is 3 cycles per transaction. Memory must return rvalid ≥1 cycle after accept.
- `gnt` is combinational from `i_mem_ready`. `rvalid`/`rdata` are registered, with 1-cycle latency from `i_mem_rvalid`.
- `o_if_rvalid` and `o_d_rvalid` are never high in the same cycle.

## Configuration
- Macro: `MEM_ARB_TIMEOUT_EN`.
- Defined:
  - A counter cleared on entry to ISSUE increments each cycle in ISSUE/WAIT.
  - When it reaches `TIMEOUT`-1 without completion, the FSM goes to IDLE.
  - Next cycle, `o_timeout` and the owner's `o_*_rvalid` pulse with rdata=0.
  - If `i_mem_rvalid` or `i_mem_ready` arrives in that final cycle, it takes precedence: normal completion, no timeout.
- Undefined: no counter; the FSM waits indefinitely; `o_timeout` is tied 0.

## Test plan
- Reset mid-WAIT with `i_rst`=1 asynchronously → all outputs 0 immediately; late `i_mem_rvalid` after reset → no `o_*_rvalid`.
- Fetch only, addr 0x100, mem ready at N+1, rvalid at N+2 with data 0x00500093 → `o_if_gnt` at N+1; `o_if_rvalid`=1 with `o_if_rdata`=0x00500093 at N+3.
- Both requests high continuously, back-to-back → grant order D, IF, D, IF; `if_prio` alternates; neither starves.
- Store addr 0x200, wdata 0xDEADBEEF, mask 4'b0011 → `o_mem_wen`=1 and payload exact while `o_mem_req`=1; `o_d_rvalid` one cycle after ack.
- Memory holds `i_mem_ready`=0 for 5 cycles → `o_mem_req` stays high, payload stable, single `gnt` pulse on accept.
- With `MEM_ARB_TIMEOUT_EN`, `TIMEOUT`=8, no rvalid → `o_timeout` and `o_d_rvalid` pulse with rdata=0; the next queued fetch is then serviced normally.
